// File: rtl/max_reload_ctrl_pkg.sv
// Shared types and defaults for the max reload controller.
// Holds the value width, the max_t type and the reset max.
package max_reload_ctrl_pkg;

  localparam int MRC_WIDTH = 8;
  localparam int MRC_DEPTH = 2;

  typedef logic [MRC_WIDTH-1:0] max_t;

  localparam max_t MRC_RESET_MAX = '0;

  // Pointer width that stays legal for a 1-entry queue.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reload_fifo.sv
// Small synchronous FIFO holding queued max values.
// Ports: push/pop/flush/din in; head/count/full out.
module reload_fifo
  import max_reload_ctrl_pkg::*;
#(
  parameter int WIDTH = MRC_WIDTH,
  parameter int DEPTH = MRC_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (cnt_q != '0) && !flush;
  assign head    = mem[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/max_reload_ctrl.sv
// Queues new counter max values, applying each at a wrap.
// Ports: clk/rst, count in, req handshake, flush, max/applied/pending.
module max_reload_ctrl
  import max_reload_ctrl_pkg::*;
#(
  parameter int               WIDTH     = MRC_WIDTH,
  parameter int               DEPTH     = MRC_DEPTH,
  parameter logic [WIDTH-1:0] RESET_MAX = WIDTH'(MRC_RESET_MAX)
) (
  input  logic                       _i_clk,
  input  logic                       _i_rst,
  input  logic [WIDTH-1:0]           _i_count,
  input  logic                       _i_req_valid,
  input  logic [WIDTH-1:0]           _i_req_max,
  output logic                       _o_req_ready,
  input  logic                       _i_flush,
  output logic [WIDTH-1:0]           _o_max,
  output logic                       _o_applied,
  output logic [$clog2(DEPTH+1)-1:0] _o_pending
);

  logic [WIDTH-1:0]           max_q;
  logic                       app_q;
  logic [WIDTH-1:0]           head;
  logic [$clog2(DEPTH+1)-1:0] cnt;
  logic                       full;
  logic                       accept;
  logic                       boundary;
  logic                       pop;

  // Ready looks only at the registered fill level,
  // never at a same-cycle pop.
  assign _o_req_ready = !_i_rst && !full;
  assign accept       = _i_req_valid && _o_req_ready;

  // Count above max is not a wrap: counter is off-track.
  assign boundary = (_i_count == max_q);

  // Pop uses the pre-edge level, so a push into an
  // empty queue waits for the next wrap.
  assign pop = boundary && (cnt != '0) && !_i_flush;

  reload_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (_i_clk),
    .rst   (_i_rst),
    .push  (accept),
    .pop   (pop),
    .flush (_i_flush),
    .din   (_i_req_max),
    .head  (head),
    .count (cnt),
    .full  (full)
  );

  always_ff @(posedge _i_clk or posedge _i_rst) begin
    if (_i_rst) begin
      max_q <= RESET_MAX;
      app_q <= 1'b0;
    end else begin
      app_q <= pop;
      if (pop) max_q <= head;
    end
  end

  assign _o_max     = max_q;
  assign _o_applied = app_q;
  assign _o_pending = cnt;

endmodule

// File: tb/tb_max_reload_ctrl.sv
// Self-checking bench for max_reload_ctrl.
// Table vectors, hand sequences and a random model run.
module tb_max_reload_ctrl;
  import max_reload_ctrl_pkg::*;

  localparam int D = 2;
  localparam logic [7:0] RM = 8'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       valid;
  logic [7:0] reqmax;
  logic       ready;
  logic       flush;
  logic [7:0] maxo;
  logic       applied;
  logic [1:0] pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max_reload_ctrl #(
    .WIDTH     (8),
    .DEPTH     (D),
    .RESET_MAX (RM)
  ) dut (
    ._i_clk       (clk),
    ._i_rst       (rst),
    ._i_count     (count),
    ._i_req_valid (valid),
    ._i_req_max   (reqmax),
    ._o_req_ready (ready),
    ._i_flush     (flush),
    ._o_max       (maxo),
    ._o_applied   (applied),
    ._o_pending   (pend)
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c,
                       input logic v,
                       input logic [7:0] m,
                       input logic f);
    count  = c;
    valid  = v;
    reqmax = m;
    flush  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain queue plus active max.
  int         q[$];
  logic [7:0] mmax;
  logic       mapp;

  task automatic model_reset();
    q.delete();
    mmax = RM;
    mapp = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    bit bnd;
    acc = valid && (q.size() < D);
    bnd = (count == mmax);
    mapp = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (bnd && q.size() > 0) begin
        mmax = 8'(q.pop_front());
        mapp = 1'b1;
      end
      if (acc) q.push_back(int'(reqmax));
    end
  endtask

  task automatic model_step();
    chk("rnd_ready", ready, (q.size() < D));
    model_edge();
    tick();
    chk("rnd_max", maxo, mmax);
    chk("rnd_applied", applied, mapp);
    chk("rnd_pending", pend, q.size());
  endtask

  typedef struct {
    logic [7:0] c;
    logic       v;
    logic [7:0] m;
    logic       f;
    logic [7:0] emax;
    logic       eapp;
    logic [1:0] epend;
    logic       erdy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [7:0] cnt;

    tbl[0]  = '{8'd0, 1'b1, 8'd4, 1'b0, 8'd2, 1'b0, 2'd1, 1'b1};
    tbl[1]  = '{8'd1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0, 2'd1, 1'b1};
    tbl[2]  = '{8'd2, 1'b0, 8'd0, 1'b0, 8'd4, 1'b1, 2'd0, 1'b1};
    tbl[3]  = '{8'd0, 1'b1, 8'd5, 1'b0, 8'd4, 1'b0, 2'd1, 1'b1};
    tbl[4]  = '{8'd1, 1'b1, 8'd6, 1'b0, 8'd4, 1'b0, 2'd2, 1'b0};
    tbl[5]  = '{8'd2, 1'b1, 8'd7, 1'b0, 8'd4, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{8'd4, 1'b1, 8'd7, 1'b0, 8'd5, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{8'd0, 1'b1, 8'd7, 1'b0, 8'd5, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{8'd9, 1'b0, 8'd0, 1'b0, 8'd5, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{8'd5, 1'b0, 8'd0, 1'b0, 8'd6, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{8'd6, 1'b0, 8'd0, 1'b1, 8'd6, 1'b0, 2'd0, 1'b1};
    tbl[11] = '{8'd6, 1'b1, 8'd3, 1'b0, 8'd6, 1'b0, 2'd1, 1'b1};
    tbl[12] = '{8'd0, 1'b0, 8'd0, 1'b0, 8'd6, 1'b0, 2'd1, 1'b1};
    tbl[13] = '{8'd6, 1'b1, 8'd9, 1'b1, 8'd6, 1'b0, 2'd0, 1'b1};
    tbl[14] = '{8'd6, 1'b1, 8'd6, 1'b0, 8'd6, 1'b0, 2'd1, 1'b1};
    tbl[15] = '{8'd6, 1'b0, 8'd0, 1'b0, 8'd6, 1'b1, 2'd0, 1'b1};
    tbl[16] = '{8'd6, 1'b0, 8'd0, 1'b0, 8'd6, 1'b0, 2'd0, 1'b1};

    // Reset state while reset is held.
    rst = 1'b1;
    drive(8'd0, 1'b0, 8'd0, 1'b0);
    #12;
    chk("rst_max", maxo, RM);
    chk("rst_pending", pend, 0);
    chk("rst_ready", ready, 0);
    chk("rst_applied", applied, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", ready, 1);

    // Idle with an attached counter: max holds, no pulses.
    cnt = 8'd0;
    for (int i = 0; i < 6; i++) begin
      count = cnt;
      tick();
      chk("idle_max", maxo, RM);
      chk("idle_applied", applied, 0);
      chk("idle_ready", ready, 1);
      cnt = (cnt == RM) ? 8'd0 : cnt + 8'd1;
    end

    // Directed vector table.
    drive(8'd0, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].m, tbl[i].f);
      tick();
      chk($sformatf("tbl%0d_max", i), maxo, tbl[i].emax);
      chk($sformatf("tbl%0d_app", i), applied, tbl[i].eapp);
      chk($sformatf("tbl%0d_pend", i), pend, tbl[i].epend);
      chk($sformatf("tbl%0d_rdy", i), ready, tbl[i].erdy);
    end

    // Mid-operation async reset.
    drive(8'd0, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst2_max", maxo, RM);
    @(negedge clk);
    rst = 1'b0;
    drive(8'd0, 1'b1, 8'd4, 1'b0);
    tick();
    drive(8'd2, 1'b0, 8'd0, 1'b0);
    tick();
    drive(8'd0, 1'b1, 8'd5, 1'b0);
    tick();
    drive(8'd1, 1'b1, 8'd6, 1'b0);
    tick();
    drive(8'd1, 1'b0, 8'd0, 1'b0);
    chk("pre_rst_max", maxo, 4);
    chk("pre_rst_pend", pend, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_max", maxo, RM);
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_app", applied, 0);
    tick();
    chk("hold_rst_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel2_ready", ready, 1);

    // Randomized run against the queue model.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 2) == 0) ? mmax
                                      : 8'($urandom_range(0, 7));
      drive(c, 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0));
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/max_reload_ctrl.md
# max_reload_ctrl

Upstream configuration stage for the wrapping `counter`: it owns the counter's `max` input. Software or a sequencer pushes new terminal values over a valid/ready handshake. The block queues them and applies each one only at a wrap boundary, so the counter never sees a `max` change mid-period. It observes the counter's output to detect the boundary.

## Interface
Parameters:
- `WIDTH`, 8, width of count and max values (matches `counter`)
- `DEPTH`, 2, pending-value queue depth (≥1)
- `RESET_MAX`, 0, value driven on `_o_max` out of reset

Ports:
- `_i_clk`  in  1  clock; the single clock domain
- `_i_rst`  in  1  reset, asynchronous, active-high
- `_i_count`  in  WIDTH  current counter value (counter's `__output`)
- `_i_req_valid`  in  1  new max value offered
- `_i_req_max`  in  WIDTH  offered max value
- `_o_req_ready`  out  1  queue can accept a value this cycle
- `_i_flush`  in  1  discard all pending values
- `_o_max`  out  WIDTH  active max; drives counter `_i_max`
- `_o_applied`  out  1  one-cycle pulse: `_o_max` took a new value this cycle
- `_o_pending`  out  clog2(DEPTH+1)  number of queued values

## Operation
- **Reset (async, any time):**
  - queue emptied, `_o_max`=RESET_MAX, `_o_applied`=0, `_o_pending`=0.
  - `_o_req_ready`=0 while `_i_rst` is high; =1 from the first cycle after release.
- **Accept:** at a rising edge with `_i_req_valid & _o_req_ready`, `_i_req_max` is enqueued at the tail, in FIFO order.
- **Ready:** `_o_req_ready = !_i_rst && pending < DEPTH`. It does not depend on a same-cycle pop, so there is no combinational path from `_i_count` to ready.
- **Wrap boundary:** the cycle in which `_i_count == _o_max`, meaning the counter returns to 0 at the next edge.
- **Apply:** at a boundary edge with pending > 0:
  - head is popped into `_o_max`;
  - `_o_applied`=1 for the following cycle;
  - the counter therefore uses the new max from its 0 cycle onward.
  - Applying a value equal to the current max still pops and pulses.
- **No-op boundary:** boundary with an empty queue changes nothing.
- **Simultaneous push and pop:**
  - both happen and pending is unchanged.
  - If the queue was empty, the pushed value is not applied at this boundary; it waits for the next one.
- **Flush:** at an edge with `_i_flush`=1:
  - the queue is emptied;
  - a same-cycle accepted push is discarded;
  - a same-cycle boundary pop is suppressed, so `_o_max` is unchanged and `_o_applied`=0.
- **Out-of-range count** (`_i_count > _o_max`, e.g. after an external counter reset or a RESET_MAX mismatch): not a boundary; no apply.
- **Arithmetic:** compares are unsigned, WIDTH bits; no arithmetic on values. Pointers wrap modulo DEPTH.

## Timing
- All outputs are registered except `_o_req_ready`, which is combinational from the pending register and `_i_rst`.
- **Push to apply:**
  - the value becomes visible on `_o_max` at the first boundary edge strictly after the accept edge, once all earlier entries are applied;
  - minimum latency is 1 cycle, when the accept edge is followed by a boundary cycle.
- `_o_applied` aligns with the first cycle the new `_o_max` is visible.
- Throughput: one push and one apply per cycle.

## Structure
- Shared package:
  - `WIDTH` default;
  - a `max_t` typedef (`logic [WIDTH-1:0]`);
  - the `RESET_MAX` default.
- Sub-module `reload_fifo`:
  - DEPTH-entry synchronous FIFO;
  - push/pop/flush inputs; head, count, and full outputs;
  - async active-high reset.
- Top level holds the boundary compare, the `_o_max` register, and the applied pulse.

## Test plan
- **Reset/idle:** RESET_MAX=2, counter attached, no pushes → `_o_max`=2; count runs 0,1,2,0,1,2; `_o_applied` never set; ready=1 after reset.
- **Deferred apply:** push 4 while count=0 (max 2) → count 1,2; `_o_max`=4 and `_o_applied`=1 in the cycle count shows 0; count continues 1,2,3,4,0.
- **Full/backpressure:** DEPTH=2, push 5, 6, and hold 7 valid → ready=0 after 2 accepts; 7 is accepted only the cycle after the first apply; applies occur in order 5, 6, 7 at successive boundaries.
- **Push on boundary with empty queue:** push 3 in the cycle count==max=2 → no apply at that edge; 3 applies at the next boundary; pending reads 1 in between.
- **Flush collision:** queue {5}; at a boundary cycle assert flush together with a push of 9 → `_o_max` stays 2, `_o_applied`=0, pending=0, 9 is dropped.
- **Mid-operation reset:** queue {5,6}, `_o_max`=4, assert `_i_rst` mid-cycle → outputs immediately show `_o_max`=RESET_MAX, pending=0, ready=0, without waiting for a clock edge.
